// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the load/store unit.
package lsu_pkg;

    // RISC-V funct3 size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Size/sign code legality; 64-bit-only codes need is64.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store, input logic is64);
        logic ok;
        ok = 1'b0;
        if (store) begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = is64;
                default:          ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = is64;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Low address bits that must be zero for an access of 2**size bytes.
    // funct3[1:0] is the log2 byte size for every legal code.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: bus address/enables/write data for stores and
// shift + sign/zero extension of returned load data.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN-1:0]   load_data_o
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [1:0]      size;
    logic [OFFW-1:0] off;
    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] wrep;
    logic [XLEN-1:0] shifted;

    // Lane offset, enables, replicated store data and extended load data.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        size = funct3_i[1:0];
        // Misaligned requests only get here when alignment faults are disabled,
        // so rounding the offset down is the force-align behaviour.
        off = addr_i[OFFW-1:0] & ~OFFW'(align_mask(size));

        case (size)
            2'd0:    size_mask = NB'(1);
            2'd1:    size_mask = NB'(3);
            2'd2:    size_mask = NB'(15);
            default: size_mask = {NB{1'b1}};
        endcase

        for (int i = 0; i < NB; i++) begin
            wrep[i*8 +: 8] = wdata_i[(i & int'(align_mask(size)))*8 +: 8];
        end

        mem_addr_o  = {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
        mem_be_o    = store_i ? (size_mask << off) : '0;
        mem_wdata_o = store_i ? wrep : '0;

        shifted = rdata_i >> {off, 3'b000};
        case (funct3_i)
            F3_B:    load_data_o = XLEN'($signed(shifted[7:0]));
            F3_H:    load_data_o = XLEN'($signed(shifted[15:0]));
            F3_W:    load_data_o = XLEN'($signed(shifted[31:0]));
            F3_BU:   load_data_o = XLEN'(shifted[7:0]);
            F3_HU:   load_data_o = XLEN'(shifted[15:0]);
            F3_WU:   load_data_o = XLEN'(shifted[31:0]);
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Sequential load/store bus master: request capture and checking,
// request/grant/response handshake, bus timeout and one-cycle completion.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ALIGN_CHECK = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e      state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [1:0]      err_q;
    logic            req_ready_q, mem_req_q, resp_valid_q;

    logic            req_illegal, req_misalign, timeout_hit;
    logic [XLEN-1:0] lane_addr, lane_wdata, lane_load;
    logic [NB-1:0]   lane_be;

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .store_i    (store_q),
        .funct3_i   (funct3_q),
        .addr_i     (addr_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .mem_addr_o (lane_addr),
        .mem_be_o   (lane_be),
        .mem_wdata_o(lane_wdata),
        .load_data_o(lane_load)
    );

    assign req_illegal  = !f3_legal(req_funct3, req_store, XLEN == 64);
    assign req_misalign = (ALIGN_CHECK != 0) &&
                          ((req_addr[2:0] & align_mask(req_funct3[1:0])) != 3'b000);
    assign cnt_d        = cnt_q + CW'(1);
    assign timeout_hit  = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    // Bus-side outputs are only driven while a request is on the bus.
    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_req_q & store_q;
    assign mem_addr   = mem_req_q ? lane_addr  : '0;
    assign mem_be     = mem_req_q ? lane_be    : '0;
    assign mem_wdata  = mem_req_q ? lane_wdata : '0;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_valid_q ? rdata_q : '0;
    assign resp_err   = resp_valid_q ? err_q   : ERR_OK;

    // Transaction FSM with registered handshake outputs and timeout counter.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= ERR_OK;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q     <= req_store;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        rdata_q     <= '0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (req_illegal) begin
                            err_q        <= ERR_ILLEGAL;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (req_misalign) begin
                            err_q        <= ERR_MISALIGN;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            err_q     <= ERR_OK;
                            mem_req_q <= 1'b1;
                            state_q   <= BUS;
                        end
                    end
                end
                BUS: begin
                    cnt_q <= cnt_d;
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (store_q) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q    <= 1'b0;
                        err_q        <= ERR_TIMEOUT;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mem_rvalid) begin
                        rdata_q      <= lane_load;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (timeout_hit) begin
                        err_q        <= ERR_TIMEOUT;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    mem_req_q    <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: a 32-bit unit (alignment faults, TIMEOUT=4) and a
// 64-bit unit (force-align, default timeout). Expected responses are queued at
// issue time and compared by per-unit monitors whenever resp_valid pulses.
`timescale 1ns/1ps
module tb_lsu_bus;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        reset;
    logic        sel;          // 0 drives the 32-bit unit, 1 the 64-bit unit
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        r32_ready, r32_valid, m32_req, m32_we;
    logic [31:0] r32_rdata, m32_addr, m32_wdata;
    logic [1:0]  r32_err;
    logic [3:0]  m32_be;

    logic        r64_ready, r64_valid, m64_req, m64_we;
    logic [63:0] r64_rdata, m64_addr, m64_wdata;
    logic [1:0]  r64_err;
    logic [7:0]  m64_be;

    lsu_bus #(.XLEN(32), .ALIGN_CHECK(1), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(r32_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_valid), .resp_rdata(r32_rdata), .resp_err(r32_err),
        .mem_req(m32_req), .mem_gnt(mem_gnt & ~sel), .mem_we(m32_we), .mem_addr(m32_addr),
        .mem_be(m32_be), .mem_wdata(m32_wdata), .mem_rvalid(mem_rvalid & ~sel),
        .mem_rdata(mem_rdata[31:0])
    );

    lsu_bus #(.XLEN(64), .ALIGN_CHECK(0), .TIMEOUT(255)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(r64_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r64_valid), .resp_rdata(r64_rdata), .resp_err(r64_err),
        .mem_req(m64_req), .mem_gnt(mem_gnt & sel), .mem_we(m64_we), .mem_addr(m64_addr),
        .mem_be(m64_be), .mem_wdata(m64_wdata), .mem_rvalid(mem_rvalid & sel),
        .mem_rdata(mem_rdata)
    );

    wire        ready_m = sel ? r64_ready : r32_ready;
    wire        mreq_m  = sel ? m64_req   : m32_req;
    wire        mwe_m   = sel ? m64_we    : m32_we;
    wire [63:0] maddr_m = sel ? m64_addr  : {32'h0, m32_addr};
    wire [63:0] mwd_m   = sel ? m64_wdata : {32'h0, m32_wdata};
    wire [7:0]  mbe_m   = sel ? m64_be    : {4'h0, m32_be};

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: compare every completion against the oldest expectation.
    always @(negedge clk) begin
        if (r32_valid) begin
            if (q32.size() == 0) begin
                check("resp32_unexpected", r32_valid, 1'b0);
            end else begin
                e32 = q32.pop_front();
                check("resp32_rdata", {32'h0, r32_rdata}, e32.rdata);
                check("resp32_err", r32_err, e32.err);
                check("resp32_cycle", cyc, e32.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (r64_valid) begin
            if (q64.size() == 0) begin
                check("resp64_unexpected", r64_valid, 1'b0);
            end else begin
                e64 = q64.pop_front();
                check("resp64_rdata", r64_rdata, e64.rdata);
                check("resp64_err", r64_err, e64.err);
                check("resp64_cycle", cyc, e64.cyc);
            end
        end
    end

    // Present one request at a negedge; lat < 0 means no response is expected.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] exp_rd,
                         input logic [1:0] exp_err, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_m) check("req_ready_wait", ready_m, 1'b1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (lat >= 0) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + lat;
            if (sel) q64.push_back(e);
            else     q32.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Hold off the grant for 'stalls' BUS cycles, checking the bus stays stable.
    task automatic bus_phase(input int stalls, input logic [63:0] addr, input logic [7:0] be,
                             input logic [63:0] wd, input bit we);
        for (int i = 0; i <= stalls; i++) begin
            check("mem_req_bus", mreq_m, 1'b1);
            check("mem_addr", maddr_m, addr);
            check("mem_be", mbe_m, be);
            check("mem_we", mwe_m, we);
            if (we) check("mem_wdata", mwd_m, wd);
            mem_gnt = (i == stalls);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
    endtask

    // Return read data after 'delay' empty WAIT cycles.
    task automatic read_phase(input int delay, input logic [63:0] rd);
        for (int i = 0; i < delay; i++) begin
            check("mem_req_wait", mreq_m, 1'b0);
            @(negedge clk);
        end
        check("mem_req_wait", mreq_m, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_missing", q32.size() + q64.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; reset = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset state of both units
        check("rst32_ready", r32_ready, 1'b1);
        check("rst32_resp", r32_valid, 1'b0);
        check("rst32_req", m32_req, 1'b0);
        check("rst32_be", m32_be, 4'h0);
        check("rst64_ready", r64_ready, 1'b1);
        check("rst64_req", m64_req, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // 32-bit: LB 0x103 -> sign-extended 0x80, resp at T+3
        issue(1'b0, F3_B, 64'h103, 64'h0, 64'hFFFF_FF80, ERR_OK, 3);
        bus_phase(0, 64'h100, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h80FF_0000);
        drain();

        // SH 0x2 with grant withheld until the last cycle before timeout
        issue(1'b1, F3_H, 64'h2, 64'h1234_ABCD, 64'h0, ERR_OK, 5);
        bus_phase(3, 64'h0, 8'h0C, 64'hABCD_ABCD, 1'b1);
        drain();

        // Faults: misaligned LW, LD on 32-bit, store with unsigned code
        issue(1'b0, F3_W, 64'h6, 64'h0, 64'h0, ERR_MISALIGN, 1);
        check("fault_no_req", mreq_m, 1'b0);
        issue(1'b0, F3_D, 64'h8, 64'h0, 64'h0, ERR_ILLEGAL, 1);
        check("illegal_no_req", mreq_m, 1'b0);
        issue(1'b1, F3_BU, 64'h0, 64'hFF, 64'h0, ERR_ILLEGAL, 1);
        drain();

        // Timeout: granted load, no read data; late rvalid in IDLE is ignored
        issue(1'b0, F3_W, 64'h8, 64'h0, 64'h0, ERR_TIMEOUT, 5);
        bus_phase(0, 64'h8, 8'h00, 64'h0, 1'b0);
        repeat (3) begin
            check("mem_req_to", mreq_m, 1'b0);
            @(negedge clk);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check("late_rvalid_ready", r32_ready, 1'b1);
        issue(1'b0, F3_HU, 64'h6, 64'h0, 64'h0000_8001, ERR_OK, 3);
        bus_phase(0, 64'h4, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h8001_0000);
        drain();

        // Reset while waiting for read data aborts without a response
        issue(1'b0, F3_W, 64'h0, 64'h0, 64'h0, ERR_OK, -1);
        bus_phase(0, 64'h0, 8'h00, 64'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_ready", r32_ready, 1'b1);
        check("midrst_resp", r32_valid, 1'b0);
        check("midrst_req", m32_req, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("midrst_ready2", r32_ready, 1'b1);
        issue(1'b0, F3_B, 64'h1, 64'h0, 64'h0000_007F, ERR_OK, 3);
        bus_phase(0, 64'h0, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h0000_7F00);
        drain();

        // 64-bit unit
        sel = 1'b1;
        @(negedge clk);
        issue(1'b0, F3_WU, 64'h14, 64'h0, 64'h0000_0000_8765_4321, ERR_OK, 4);
        bus_phase(0, 64'h10, 8'h00, 64'h0, 1'b0);
        read_phase(1, 64'h8765_4321_0000_0000);
        issue(1'b0, F3_W, 64'h14, 64'h0, 64'hFFFF_FFFF_8765_4321, ERR_OK, 3);
        bus_phase(0, 64'h10, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h8765_4321_0000_0000);
        issue(1'b0, F3_D, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF, ERR_OK, 3);
        bus_phase(0, 64'h8, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h0123_4567_89AB_CDEF);
        // Misaligned LH is force-aligned to offset 2
        issue(1'b0, F3_H, 64'h13, 64'h0, 64'hFFFF_FFFF_FFFF_F00D, ERR_OK, 3);
        bus_phase(0, 64'h10, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h0000_0000_F00D_0000);
        issue(1'b0, F3_BU, 64'h7, 64'h0, 64'h0000_0000_0000_0099, ERR_OK, 3);
        bus_phase(0, 64'h0, 8'h00, 64'h0, 1'b0);
        read_phase(0, 64'h9900_0000_0000_0000);
        drain();

        // 64-bit stores: force-aligned SW, SB with a stall, SD
        issue(1'b1, F3_W, 64'h7, 64'hDEAD_BEEF, 64'h0, ERR_OK, 2);
        bus_phase(0, 64'h0, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        issue(1'b1, F3_B, 64'h5, 64'h1122_3344_5566_77A5, 64'h0, ERR_OK, 3);
        bus_phase(1, 64'h0, 8'h20, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        issue(1'b1, F3_D, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0, ERR_OK, 2);
        bus_phase(0, 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
        drain();

        // 64-bit illegal codes
        issue(1'b1, F3_WU, 64'h0, 64'h0, 64'h0, ERR_ILLEGAL, 1);
        issue(1'b0, 3'b111, 64'h0, 64'h0, 64'h0, ERR_ILLEGAL, 1);
        drain();

        repeat (3) @(negedge clk);
        check("q32_left", q32.size(), 0);
        check("q64_left", q64.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
